// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: synchronises and deglitches the PS/2 lines,
// assembles 11-bit frames (start, 8 data LSB first, odd parity, stop) and strobes the result.
module ps2_rx_frame #(
    parameter int FILTER  = 4,
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_error,
    output logic       busy
);

    localparam int TW = ($clog2(TIMEOUT + 1) > 16) ? $clog2(TIMEOUT + 1) : 16;
    localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          ps2c_s1_q, ps2c_s2_q, ps2d_s1_q, ps2d_s2_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_error_q, rx_error_d;

    // The filtered level flips on the FILTER-th consecutive cycle of disagreement.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (ps2c_s2_q != filt_q) begin
            if (filt_cnt_q == FW'(FILTER - 1)) begin
                filt_d = ps2c_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
    end

    assign fall = filt_q & ~filt_d;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_error_d = 1'b0;
        tmo_d      = (state_q == IDLE) ? '0 : tmo_q + TW'(1);

        if (fall) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    if (!ps2d_s2_q) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {ps2d_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = ps2d_s2_q;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (ps2d_s2_q && ((^shift_q) ^ parity_q)) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_error_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if ((state_q != IDLE) && (tmo_q == TW'(TIMEOUT))) begin
            // Line went quiet mid-frame: drop the partial byte.
            state_d    = IDLE;
            tmo_d      = '0;
            bit_cnt_d  = '0;
            shift_d    = '0;
            rx_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps2c_s1_q  <= 1'b1;
            ps2c_s2_q  <= 1'b1;
            ps2d_s1_q  <= 1'b1;
            ps2d_s2_q  <= 1'b1;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tmo_q      <= '0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_error_q <= 1'b0;
        end else begin
            ps2c_s1_q  <= ps2_clk;
            ps2c_s2_q  <= ps2c_s1_q;
            ps2d_s1_q  <= ps2_data;
            ps2d_s2_q  <= ps2d_s1_q;
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tmo_q      <= tmo_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_error_q <= rx_error_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_error = rx_error_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Self-checking bench for ps2_rx_frame: directed frame table, glitch/timeout/reset
// sequences and random frames scored against a parity/stop-bit reference model.
module tb_ps2_rx_frame;

    localparam int FILTER  = 4;
    localparam int TIMEOUT = 1000;
    localparam int HALF    = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_error, busy;

    int checks = 0;
    int failures = 0;
    int v_cnt = 0, e_cnt = 0, both_cnt = 0;

    ps2_rx_frame #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) v_cnt++;
        if (rx_error) e_cnt++;
        if (rx_valid && rx_error) both_cnt++;
    end

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       stop;
        int         glitch_after;
        int         exp_valid;
        int         exp_error;
        logic [7:0] exp_data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clock_bit(input logic b);
        ps2_data = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic glitch();
        ps2_clk = 1'b0;
        wait_cyc(FILTER - 1);
        ps2_clk = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int g);
        logic [10:0] bits;
        bits = {stop, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            clock_bit(bits[i]);
            if (i == g) glitch();
        end
        ps2_data = 1'b1;
        wait_cyc(20);
    endtask

    // Reference: correct odd parity bit for a byte, from a plain count of ones.
    function automatic logic odd_par(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return (ones % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic run_frame(input string name, input logic [7:0] d, input logic par,
                             input logic stop, input int g, input int ev, input int ee,
                             input logic [7:0] ed);
        int v0, e0;
        v0 = v_cnt;
        e0 = e_cnt;
        send_frame(d, par, stop, g);
        chk({name, " valid"}, v_cnt - v0, ev);
        chk({name, " error"}, e_cnt - e0, ee);
        chk({name, " data"}, {24'h0, rx_data}, {24'h0, ed});
        chk({name, " busy"}, {31'h0, busy}, 32'h0);
        $display("frame %s d=0x%02h par=%0b stop=%0b -> rx_data=0x%02h valid=%0d error=%0d",
                 name, d, par, stop, rx_data, v_cnt - v0, e_cnt - e0);
    endtask

    vec_t vecs[6];
    logic [7:0] model_data;

    initial begin
        int v0, e0;
        logic [7:0] rd;
        logic rp, rs, good;
        int ones;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, -1, 1, 0, 8'h1C};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, -1, 0, 1, 8'h1C};
        vecs[2] = '{8'h55, 1'b1, 1'b0, -1, 0, 1, 8'h1C};
        vecs[3] = '{8'h3A, 1'b1, 1'b1,  3, 1, 0, 8'h3A};
        vecs[4] = '{8'h00, 1'b1, 1'b1, -1, 1, 0, 8'h00};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, -1, 1, 0, 8'hFF};

        wait_cyc(4);
        chk("reset rx_data", {24'h0, rx_data}, 32'h0);
        chk("reset strobes", {30'h0, rx_valid, rx_error}, 32'h0);
        chk("reset busy", {31'h0, busy}, 32'h0);
        reset = 1'b1;
        wait_cyc(5);

        // Short low glitch in IDLE with data low must not look like a start bit.
        ps2_data = 1'b0;
        glitch();
        ps2_data = 1'b1;
        wait_cyc(10);
        chk("idle glitch busy", {31'h0, busy}, 32'h0);
        e0 = e_cnt;
        clock_bit(1'b1);
        wait_cyc(10);
        chk("idle data1 busy", {31'h0, busy}, 32'h0);
        chk("idle data1 error", e_cnt - e0, 0);

        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].par, vecs[i].stop,
                      vecs[i].glitch_after, vecs[i].exp_valid, vecs[i].exp_error,
                      vecs[i].exp_data);
        end
        model_data = 8'hFF;

        // Line stalls after start + 4 data bits.
        v0 = v_cnt;
        e0 = e_cnt;
        clock_bit(1'b0);
        for (int i = 0; i < 4; i++) clock_bit(1'b1);
        wait_cyc(20);
        chk("stall busy", {31'h0, busy}, 32'h1);
        wait_cyc(TIMEOUT + 50);
        chk("timeout error", e_cnt - e0, 1);
        chk("timeout valid", v_cnt - v0, 0);
        chk("timeout busy", {31'h0, busy}, 32'h0);
        $display("timeout after 4 bits -> error=%0d busy=%0b", e_cnt - e0, busy);
        run_frame("after_timeout", 8'hF0, odd_par(8'hF0), 1'b1, -1, 1, 0, 8'hF0);
        model_data = 8'hF0;

        for (int n = 0; n < 8; n++) begin
            rd = 8'($urandom_range(0, 255));
            rp = ($urandom_range(0, 3) == 0) ? ~odd_par(rd) : odd_par(rd);
            rs = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            ones = 0;
            for (int i = 0; i < 8; i++) ones += int'(rd[i]);
            good = (((ones + int'(rp)) % 2) == 1) && rs;
            if (good) model_data = rd;
            run_frame($sformatf("rand%0d", n), rd, rp, rs, -1,
                      good ? 1 : 0, good ? 0 : 1, model_data);
        end

        // Reset mid-frame after a good byte.
        run_frame("pre_reset", 8'h1C, 1'b0, 1'b1, -1, 1, 0, 8'h1C);
        e0 = e_cnt;
        clock_bit(1'b0);
        clock_bit(1'b1);
        clock_bit(1'b0);
        wait_cyc(10);
        chk("midframe busy", {31'h0, busy}, 32'h1);
        #2;
        reset = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        #1;
        chk("async rst rx_data", {24'h0, rx_data}, 32'h0);
        chk("async rst busy", {31'h0, busy}, 32'h0);
        chk("async rst strobes", {30'h0, rx_valid, rx_error}, 32'h0);
        wait_cyc(5);
        reset = 1'b1;
        wait_cyc(10);
        chk("reset no error", e_cnt - e0, 0);
        $display("reset mid-frame -> rx_data=0x%02h busy=%0b error=%0d", rx_data, busy, e_cnt - e0);
        run_frame("post_reset", 8'hAA, 1'b1, 1'b1, -1, 1, 0, 8'hAA);

        chk("valid/error overlap", both_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_rx_frame.md
PS2_RX_FRAME -- requirements
Module: ps2_rx_frame

Interface
REQ-001 SHALL have parameter FILTER, default 4: consecutive clk samples a new ps2_clk level must hold before it is accepted.
REQ-002 SHALL have parameter TIMEOUT, default 50000: clk cycles allowed between ps2_clk falling edges inside a frame.
REQ-003 SHALL have port clk  input  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-007 SHALL have port rx_data  output  8  last correctly received byte.
REQ-008 SHALL have port rx_valid  output  1  one-cycle strobe for a new rx_data; drives pulse_in of the downstream pulse expander.
REQ-009 SHALL have port rx_error  output  1  one-cycle strobe for a rejected frame.
REQ-010 SHALL have port busy  output  1  high while a frame is in progress.

Function
REQ-011 SHALL pass ps2_clk and ps2_data through two-flop synchronisers each.
REQ-012 SHALL change the filtered clock level only after the synchronised ps2_clk differs from it for FILTER consecutive cycles; a shorter pulse SHALL produce no change.
REQ-013 SHALL produce a fall event, one cycle wide, in the cycle the filtered clock changes 1->0; ps2_data SHALL be sampled from its second sync flop in that cycle.
REQ-014 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: on a fall event with data=0 (start), go to DATA and clear the bit counter; with data=1, stay in IDLE with no error.
REQ-016 DATA: on each fall event, shift data in LSB first; after the 8th bit go to PARITY.
REQ-017 PARITY: on a fall event, latch the parity bit and go to STOP.
REQ-018 Parity SHALL be odd: XOR of the 8 data bits and the parity bit must be 1.
REQ-019 STOP: on a fall event, return to IDLE; if stop=1 and parity ok, load rx_data and assert rx_valid; otherwise assert rx_error and leave rx_data unchanged.
REQ-020 rx_valid and rx_error SHALL be registered and high exactly one cycle, in the cycle after the stop-bit fall event; they are never high together.
REQ-021 SHALL keep a timeout counter, at least 16 bits and wide enough for TIMEOUT; it clears on every fall event and while in IDLE, and increments otherwise.
REQ-022 When the counter reaches TIMEOUT outside IDLE, SHALL go to IDLE, discard the partial frame and strobe rx_error for one cycle.
REQ-023 If a fall event and timeout occur in the same cycle, the fall event SHALL win: the counter clears and the FSM advances normally.
REQ-024 busy SHALL equal (state != IDLE), from registered state.
REQ-025 rx_data SHALL hold its value until the next valid frame.

Reset
REQ-026 While reset=0, SHALL asynchronously force:
  - state IDLE
  - bit counter, timeout counter, shift register = 0
  - rx_data = 0x00
  - rx_valid = rx_error = busy = 0
  - sync flops and filtered clock = 1
REQ-027 Reset asserted mid-frame SHALL abandon the frame without an rx_error strobe.
REQ-028 After release, reception SHALL start only at the next start bit.

Verification
REQ-029 Frame 0x1C, parity 0, stop 1 -> rx_data=0x1C, rx_valid high one cycle, rx_error 0, busy low after stop.
REQ-030 Frame 0x1C, parity 1 -> rx_error one cycle, rx_valid 0, rx_data keeps its prior value.
REQ-031 Frame 0x55, correct parity, stop bit 0 -> rx_error one cycle, rx_data unchanged.
REQ-032 ps2_clk low glitches of FILTER-1 cycles, in IDLE and mid-frame -> no fall event, state and bit count unchanged.
REQ-033 ps2_clk stops after 4 data bits for TIMEOUT cycles -> rx_error one cycle, busy 0; following frame 0xF0 -> rx_data=0xF0, rx_valid.
REQ-034 reset=0 mid-frame after 0x1C was received -> all outputs 0 immediately, no rx_error; after release, frame 0xAA with parity 1 -> rx_data=0xAA, rx_valid one cycle.
